// File: rtl/uart_memory_controller.sv
// Byte-command front end for an on-chip RAM: WRITE (cmd,addr,data) and READ (cmd,addr) from uart_rx, replies to uart_tx.
// Optional macro CMD_ERROR_EN: an unrecognised opcode in IDLE is answered with tx_byte=8'hEE.
`ifndef COMMAND_WRITE
`define COMMAND_WRITE 8'h01
`endif
`ifndef COMMAND_READ
`define COMMAND_READ 8'h02
`endif

module uart_memory_controller #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [7:0]  CMD_WRITE  = `COMMAND_WRITE,
  parameter logic [7:0]  CMD_READ   = `COMMAND_READ
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  received,
  input  logic [7:0]            rx_byte,
  output logic                  transmit,
  output logic [DATA_WIDTH-1:0] tx_byte
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;

`ifdef CMD_ERROR_EN
  localparam logic [DATA_WIDTH-1:0] ERR_BYTE = DATA_WIDTH'(8'hEE);
`endif

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_transmit;
  logic [DATA_WIDTH-1:0] r_tx_byte;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_addr_we;
  logic                  w_mem_we;
  logic                  w_rd_req;
  logic                  w_err;

  // Command parser: bytes are consumed only on strobed edges, except RD_RESP which always advances.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_we   = 1'b0;
    w_mem_we    = 1'b0;
    w_rd_req    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (received) begin
          if (rx_byte == CMD_WRITE) begin
            w_state_nxt = S_WR_ADDR;
          end else if (rx_byte == CMD_READ) begin
            w_state_nxt = S_RD_ADDR;
          end else begin
`ifdef CMD_ERROR_EN
            w_err = 1'b1;
`endif
          end
        end
      end
      S_WR_ADDR: begin
        if (received) begin
          w_addr_we   = 1'b1;
          w_state_nxt = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (received) begin
          w_mem_we    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (received) begin
          w_addr_we   = 1'b1;
          w_state_nxt = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        w_rd_req    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_addr_we) begin
        r_addr <= ADDR_WIDTH'(rx_byte);
      end
    end
  end

  // RAM array is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= DATA_WIDTH'(rx_byte);
    end
  end

  // Registered read port doubles as the held transmit byte.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_transmit <= 1'b0;
      r_tx_byte  <= '0;
    end else begin
      r_transmit <= w_rd_req | w_err;
      if (w_rd_req) begin
        r_tx_byte <= r_mem[r_addr];
      end
`ifdef CMD_ERROR_EN
      else if (w_err) begin
        r_tx_byte <= ERR_BYTE;
      end
`endif
    end
  end

  assign transmit = r_transmit;
  assign tx_byte  = r_tx_byte;

endmodule

// File: tb/tb_uart_memory_controller.sv
// Self-checking bench for uart_memory_controller: byte-stream command model plus directed literal checks.
// Honours CMD_ERROR_EN the same way as the design when compiled with that macro.
module tb_uart_memory_controller;

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b1;
  logic       received = 1'b0;
  logic [7:0] rx_byte  = 8'h00;
  logic       transmit;
  logic [7:0] tx_byte;

  int         checks   = 0;
  int         failures = 0;
  int         pulses   = 0;
  logic [7:0] last_tx  = 8'h00;

`ifdef CMD_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // Command-level model state
  logic [7:0] mem_m [256];
  bit         known_m [256];
  logic [7:0] cmd_q [$];
  bit         exp_transmit = 1'b0;
  logic [7:0] exp_tx       = 8'h00;
  bit         exp_known    = 1'b1;
  bit         pend_valid   = 1'b0;
  logic [7:0] pend_byte    = 8'h00;
  bit         pend_known   = 1'b0;

  uart_memory_controller dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .received (received),
    .rx_byte  (rx_byte),
    .transmit (transmit),
    .tx_byte  (tx_byte)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one received byte to the model's command buffer.
  task automatic model_byte(input logic [7:0] b);
    if (cmd_q.size() == 0) begin
      if (b == 8'h01 || b == 8'h02) begin
        cmd_q.push_back(b);
      end else if (ERR_EN) begin
        exp_transmit = 1'b1;
        exp_tx       = 8'hEE;
        exp_known    = 1'b1;
      end
    end else begin
      cmd_q.push_back(b);
      if (cmd_q[0] == 8'h01 && cmd_q.size() == 3) begin
        mem_m[cmd_q[1]]   = cmd_q[2];
        known_m[cmd_q[1]] = 1'b1;
        cmd_q.delete();
      end else if (cmd_q[0] == 8'h02 && cmd_q.size() == 2) begin
        pend_valid = 1'b1;
        pend_byte  = mem_m[b];
        pend_known = known_m[b];
        cmd_q.delete();
      end
    end
  endtask

  // Model: a read answers on the edge after the address edge; a byte on that edge is lost.
  initial begin
    foreach (known_m[i]) known_m[i] = 1'b0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        cmd_q.delete();
        exp_transmit = 1'b0;
        exp_tx       = 8'h00;
        exp_known    = 1'b1;
        pend_valid   = 1'b0;
      end else begin
        exp_transmit = 1'b0;
        if (pend_valid) begin
          exp_transmit = 1'b1;
          exp_tx       = pend_byte;
          exp_known    = pend_known;
          pend_valid   = 1'b0;
        end else if (received) begin
          model_byte(rx_byte);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clock);
    #2;
    received = 1'b1;
    rx_byte  = b;
    @(posedge clock);
    #2;
    received = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    send(8'h01);
    send(a);
    send(d);
  endtask

  task automatic rd(input logic [7:0] a);
    send(8'h02);
    send(a);
  endtask

  int p0;

  initial begin
    #3 reset_n = 1'b0;
    fork
      forever begin
        @(negedge clock);
        check("transmit", 32'(transmit), 32'(exp_transmit));
        if (exp_known) check("tx_byte", 32'(tx_byte), 32'(exp_tx));
        if (transmit === 1'b1) begin
          pulses++;
          last_tx = tx_byte;
        end
      end
    join_none
    idle(3);
    reset_n = 1'b1;

    // 1: quiet after reset
    p0 = pulses;
    idle(10);
    check("t1_pulses", 32'(pulses - p0), 32'd0);
    check("t1_tx_byte", 32'(tx_byte), 32'h00);

    // 2: write then read FE
    wr(8'hFE, 8'h42);
    p0 = pulses;
    rd(8'hFE);
    idle(4);
    check("t2_pulses", 32'(pulses - p0), 32'd1);
    check("t2_byte", 32'(last_tx), 32'h42);
    check("t2_hold", 32'(tx_byte), 32'h42);

    // 3: two addresses, two reads
    wr(8'hFE, 8'h42);
    wr(8'hAB, 8'h44);
    p0 = pulses;
    rd(8'hFE);
    idle(2);
    check("t3_first", 32'(last_tx), 32'h42);
    rd(8'hAB);
    idle(4);
    check("t3_second", 32'(last_tx), 32'h44);
    check("t3_pulses", 32'(pulses - p0), 32'd2);

    // 4: overwrite
    wr(8'h10, 8'h11);
    wr(8'h10, 8'h22);
    p0 = pulses;
    rd(8'h10);
    idle(4);
    check("t4_byte", 32'(last_tx), 32'h22);
    check("t4_pulses", 32'(pulses - p0), 32'd1);

    // 5: reset mid-write leaves old data
    wr(8'h55, 8'hA5);
    send(8'h01);
    send(8'h55);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(2);
    check("t5_tx_reset", 32'(tx_byte), 32'h00);
    p0 = pulses;
    rd(8'h55);
    idle(4);
    check("t5_byte", 32'(last_tx), 32'hA5);
    check("t5_pulses", 32'(pulses - p0), 32'd1);

    // 6: unknown opcode, then FE still intact
    p0 = pulses;
    send(8'h7F);
    idle(4);
    check("t6_err_pulses", 32'(pulses - p0), ERR_EN ? 32'd1 : 32'd0);
    if (ERR_EN) check("t6_err_byte", 32'(last_tx), 32'hEE);
    p0 = pulses;
    rd(8'hFE);
    idle(4);
    check("t6_fe", 32'(last_tx), 32'h42);
    check("t6_pulses", 32'(pulses - p0), 32'd1);

    // Opcode-valued payload bytes and address extremes
    wr(8'h02, 8'h01);
    wr(8'h00, 8'h5A);
    wr(8'hFF, 8'hC3);
    rd(8'h02);
    idle(2);
    check("opc_data", 32'(last_tx), 32'h01);
    rd(8'h00);
    idle(2);
    check("addr_00", 32'(last_tx), 32'h5A);
    rd(8'hFF);
    idle(2);
    check("addr_ff", 32'(last_tx), 32'hC3);

    // Reset between address edge and response cancels the transmit
    p0 = pulses;
    rd(8'hFF);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(4);
    check("rst_cancel", 32'(pulses - p0), 32'd0);
    check("rst_cancel_tx", 32'(tx_byte), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
